// File: rtl/alu_op_issuer_pkg.sv
// Shared definitions for the ALU result-select initiator.
// Holds the opcode encodings, the legality check and the FSM states.
package alu_pkg;

  localparam logic [3:0] OP_SUMA = 4'b0000;
  localparam logic [3:0] OP_RESTA = 4'b0001;
  localparam logic [3:0] OP_DESP_IZQ = 4'b0010;
  localparam logic [3:0] OP_DESP_DER = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b0110;
  localparam logic [3:0] OP_XOR = 4'b0111;
  localparam logic [3:0] OP_NADA = 4'b1111;

  // Opcodes 1000..1110 have no ALU function behind them.
  function automatic logic is_legal(input logic [3:0] op);
    return (op[3] == 1'b0) || (op == OP_NADA);
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/alu_op_issuer_if.sv
// Instruction and result handshakes between the control unit and the issuer.
// The master side is the control unit; the slave side is the issuer.
interface alu_op_issuer_if #(
  parameter int N = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   in_opcode;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic         in_use_acc;
  logic         in_wr_acc;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_result;
  logic         out_zero;
  logic         out_sign;
  logic         out_illegal;
  logic         out_echo_err;

  modport master (
    output in_valid, in_opcode, in_a, in_b, in_use_acc, in_wr_acc, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_sign, out_illegal, out_echo_err
  );

  modport slave (
    input  in_valid, in_opcode, in_a, in_b, in_use_acc, in_wr_acc, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_sign, out_illegal, out_echo_err
  );
endinterface

// File: rtl/alu_op_issuer.sv
// Initiator for the ALU result-select path: registers one instruction,
// waits a fixed ALU latency, samples the selected result, and returns it
// with zero/sign/illegal/echo flags. Keeps an accumulator usable as operand A.
module alu_op_issuer
  import alu_pkg::*;
#(
  parameter int N       = 8,
  parameter int ALU_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_op_issuer_if.slave bus,
  output logic [N-1:0]  OperandoA,
  output logic [N-1:0]  OperandoB,
  output logic [3:0]    Operador,
  input  logic [N-1:0]  SalidaOp,
  input  logic [3:0]    OperadorSalida,
  output logic [N-1:0]  acc
);

  localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

  state_e       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [N-1:0] opa_q, opb_q, acc_q, result_q;
  logic [3:0]   opr_q;
  logic         wr_acc_q, illegal_q, zero_q, sign_q, echo_err_q;
  logic         accept, sample;

  // in_ready is forced low while reset is asserted even though the state is IDLE.
  assign bus.in_ready = (state_q == ST_IDLE) && rst_n;
  assign accept       = bus.in_valid && bus.in_ready;
  assign sample       = (state_q == ST_WAIT) && (cnt_q == 4'd0);

  // State and wait-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, wait counter and result-valid decode.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bus.out_valid = 1'b0;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_ISSUE;
      ST_ISSUE: begin
        cnt_d   = LAT_M1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_RESP: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Instruction capture at accept; result, flags and accumulator capture at sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa_q      <= '0;
      opb_q      <= '0;
      opr_q      <= OP_NADA;
      wr_acc_q   <= 1'b0;
      illegal_q  <= 1'b0;
      acc_q      <= '0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      sign_q     <= 1'b0;
      echo_err_q <= 1'b0;
    end else begin
      if (accept) begin
        // acc_q here is the value before any update by this instruction.
        opa_q     <= bus.in_use_acc ? acc_q : bus.in_a;
        opb_q     <= bus.in_b;
        opr_q     <= is_legal(bus.in_opcode) ? bus.in_opcode : OP_NADA;
        wr_acc_q  <= bus.in_wr_acc;
        illegal_q <= !is_legal(bus.in_opcode);
      end
      if (sample) begin
        result_q   <= SalidaOp;
        zero_q     <= (SalidaOp == '0);
        sign_q     <= SalidaOp[N-1];
        echo_err_q <= (OperadorSalida != opr_q);
        if (wr_acc_q) acc_q <= SalidaOp;
      end
    end
  end

  assign OperandoA        = opa_q;
  assign OperandoB        = opb_q;
  assign Operador         = opr_q;
  assign acc              = acc_q;
  assign bus.out_result   = result_q;
  assign bus.out_zero     = zero_q;
  assign bus.out_sign     = sign_q;
  assign bus.out_illegal  = illegal_q;
  assign bus.out_echo_err = echo_err_q;

endmodule

// File: tb/tb_alu_op_issuer.sv
// Directed bench for alu_op_issuer: one DUT at ALU_LAT=1 with a behavioural
// ALU, and one at ALU_LAT=4 whose "ALU" reports cycles since accept.
module tb_alu_op_issuer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- DUT 1: ALU_LAT = 1 ----------------
  alu_op_issuer_if #(.N(8)) bus1 ();
  logic [7:0] opa1, opb1, sal1, acc1;
  logic [3:0] opr1, echo1;
  logic       echo_force = 1'b0;
  logic [3:0] echo_force_val = 4'b0000;

  alu_op_issuer #(.N(8), .ALU_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1),
    .OperandoA(opa1), .OperandoB(opb1), .Operador(opr1),
    .SalidaOp(sal1), .OperadorSalida(echo1), .acc(acc1)
  );

  // Behavioural ALU result select; 1111 returns a fixed marker value.
  always_comb begin
    case (opr1)
      4'b0000: sal1 = opa1 + opb1;
      4'b0001: sal1 = opa1 - opb1;
      4'b0010: sal1 = opa1 << 1;
      4'b0011: sal1 = opa1 >> 1;
      4'b0100: sal1 = opa1 & opb1;
      4'b0101: sal1 = opa1 | opb1;
      4'b0110: sal1 = ~opa1;
      4'b0111: sal1 = opa1 ^ opb1;
      default: sal1 = 8'hA5;
    endcase
    echo1 = echo_force ? echo_force_val : opr1;
  end

  // ---------------- DUT 2: ALU_LAT = 4 ----------------
  alu_op_issuer_if #(.N(8)) bus2 ();
  logic [7:0] opa2, opb2, acc2;
  logic [3:0] opr2;
  logic [7:0] since_acc = 8'd0;

  alu_op_issuer #(.N(8), .ALU_LAT(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2),
    .OperandoA(opa2), .OperandoB(opb2), .Operador(opr2),
    .SalidaOp(since_acc), .OperadorSalida(opr2), .acc(acc2)
  );

  // Counts edges since the last accept, so the sampled value tells when the sample happened.
  always @(posedge clk) begin
    if (bus2.in_valid && bus2.in_ready) since_acc <= 8'd0;
    else                                since_acc <= since_acc + 8'd1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One full instruction on DUT 1 with optional stall cycles in RESP.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic ua, input logic wa,
                        input logic [7:0] exp_res, input logic exp_ill, input logic exp_echo,
                        input logic [3:0] exp_opr, input logic [7:0] exp_acc, input int stall);
    int cyc;
    @(negedge clk);
    bus1.in_valid = 1'b1; bus1.in_opcode = op; bus1.in_a = a; bus1.in_b = b;
    bus1.in_use_acc = ua; bus1.in_wr_acc = wa;
    chk({tag, ".in_ready"}, 32'(bus1.in_ready), 32'd1);
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
    cyc = 0;
    do begin
      @(posedge clk); cyc++;
      @(negedge clk);
    end while (!bus1.out_valid && cyc < 20);
    chk({tag, ".lat"}, 32'(cyc), 32'd2);
    chk({tag, ".result"}, 32'(bus1.out_result), 32'(exp_res));
    chk({tag, ".zero"}, 32'(bus1.out_zero), 32'(exp_res == 8'h00));
    chk({tag, ".sign"}, 32'(bus1.out_sign), 32'(exp_res[7]));
    chk({tag, ".illegal"}, 32'(bus1.out_illegal), 32'(exp_ill));
    chk({tag, ".echo_err"}, 32'(bus1.out_echo_err), 32'(exp_echo));
    chk({tag, ".Operador"}, 32'(opr1), 32'(exp_opr));
    chk({tag, ".acc"}, 32'(acc1), 32'(exp_acc));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk({tag, ".stall_valid"}, 32'(bus1.out_valid), 32'd1);
      chk({tag, ".stall_result"}, 32'(bus1.out_result), 32'(exp_res));
      chk({tag, ".stall_in_ready"}, 32'(bus1.in_ready), 32'd0);
    end
    bus1.out_ready = 1'b1;
    @(posedge clk); #1;
    bus1.out_ready = 1'b0;
    @(negedge clk);
    chk({tag, ".valid_drop"}, 32'(bus1.out_valid), 32'd0);
    chk({tag, ".ready_back"}, 32'(bus1.in_ready), 32'd1);
    $display("op %s opcode=%b a=%0h b=%0h result=%0h acc=%0h", tag, op, a, b, exp_res, exp_acc);
  endtask

  initial begin
    int cyc;
    bus1.in_valid = 1'b0; bus1.in_opcode = 4'b0000; bus1.in_a = 8'h00; bus1.in_b = 8'h00;
    bus1.in_use_acc = 1'b0; bus1.in_wr_acc = 1'b0; bus1.out_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_opcode = 4'b0000; bus2.in_a = 8'h00; bus2.in_b = 8'h00;
    bus2.in_use_acc = 1'b0; bus2.in_wr_acc = 1'b0; bus2.out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.in_ready_low", 32'(bus1.in_ready), 32'd0);
    chk("rst.Operador", 32'(opr1), 32'hF);
    chk("rst.OperandoA", 32'(opa1), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst.in_ready", 32'(bus1.in_ready), 32'd1);
    chk("rst.out_valid", 32'(bus1.out_valid), 32'd0);
    chk("rst.acc", 32'(acc1), 32'd0);

    // tag op a b use_acc wr_acc result illegal echo Operador acc_after stall
    run_op("add",     4'b0000, 8'h05, 8'h03, 1'b0, 1'b0, 8'h08, 1'b0, 1'b0, 4'b0000, 8'h00, 0);
    run_op("add_acc", 4'b0000, 8'h10, 8'h22, 1'b0, 1'b1, 8'h32, 1'b0, 1'b0, 4'b0000, 8'h32, 0);
    run_op("xor_acc", 4'b0111, 8'hFF, 8'h80, 1'b1, 1'b0, 8'hB2, 1'b0, 1'b0, 4'b0111, 8'h32, 0);
    run_op("resta",   4'b0001, 8'h04, 8'h04, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 4'b0001, 8'h00, 0);
    run_op("xor_sgn", 4'b0111, 8'h11, 8'h80, 1'b1, 1'b0, 8'h80, 1'b0, 1'b0, 4'b0111, 8'h00, 0);
    run_op("shl",     4'b0010, 8'h41, 8'h00, 1'b0, 1'b0, 8'h82, 1'b0, 1'b0, 4'b0010, 8'h00, 0);
    run_op("illegal", 4'b1010, 8'h01, 8'h02, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 4'b1111, 8'h00, 0);
    echo_force = 1'b1; echo_force_val = 4'b0011;
    run_op("or_bp",   4'b0101, 8'h0C, 8'h30, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 4'b0101, 8'h00, 5);
    echo_force = 1'b0;
    run_op("nada_wa", 4'b1111, 8'h00, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 4'b1111, 8'hA5, 0);

    // Reset during WAIT: instruction dropped, acc back to 0
    @(negedge clk);
    bus1.in_valid = 1'b1; bus1.in_opcode = 4'b0000; bus1.in_a = 8'h01; bus1.in_b = 8'h01;
    bus1.in_use_acc = 1'b0; bus1.in_wr_acc = 1'b1;
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst.Operador", 32'(opr1), 32'hF);
    chk("midrst.out_valid", 32'(bus1.out_valid), 32'd0);
    chk("midrst.acc", 32'(acc1), 32'd0);
    chk("midrst.in_ready_low", 32'(bus1.in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst.in_ready", 32'(bus1.in_ready), 32'd1);
    repeat (3) @(negedge clk);
    chk("midrst.no_result", 32'(bus1.out_valid), 32'd0);
    chk("midrst.acc_hold", 32'(acc1), 32'd0);
    $display("op midrst reset during WAIT");

    // ALU_LAT = 4 timing
    @(negedge clk);
    bus2.in_valid = 1'b1; bus2.in_opcode = 4'b0100; bus2.in_a = 8'h0F; bus2.in_b = 8'hF0;
    @(posedge clk); #1;
    bus2.in_valid = 1'b0;
    chk("lat4.Operador", 32'(opr2), 32'b0100);
    cyc = 0;
    do begin
      @(posedge clk); cyc++;
      @(negedge clk);
    end while (!bus2.out_valid && cyc < 30);
    chk("lat4.lat", 32'(cyc), 32'd5);
    chk("lat4.sample_age", 32'(bus2.out_result), 32'd4);
    chk("lat4.echo_err", 32'(bus2.out_echo_err), 32'd0);
    bus2.out_ready = 1'b1;
    @(posedge clk); #1;
    bus2.out_ready = 1'b0;
    @(negedge clk);
    chk("lat4.valid_drop", 32'(bus2.out_valid), 32'd0);
    $display("op lat4 sampled value=%0h", bus2.out_result);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
